// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache controller.
// Define DCACHE_PERF_CNT_EN to build saturating hit/miss counters; otherwise both read 0.
module dcache_controller #(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = 256
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 cpu_stall_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
);
   localparam int INDEX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 27 - INDEX_W;
   typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;
   state_t state_q, state_d;
   logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [TAG_W-1:0] tag_q [NUM_LINES];
   logic [TAG_W-1:0] tag_d [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];
   logic [LINE_BITS-1:0] data_d [NUM_LINES];
   logic [26:0] laddr_q, laddr_d;
   logic [INDEX_W-1:0] idx, midx;
   logic [TAG_W-1:0] tag;
   logic [2:0] w;
   logic hit, unused_ok;
   assign idx = cpu_addr_i[5 +: INDEX_W];
   assign tag = cpu_addr_i[31 -: TAG_W];
   assign w = cpu_addr_i[4:2];
   assign unused_ok = ^cpu_addr_i[1:0];
   // the miss line address is latched so mem_* stay stable even if the CPU lets go mid-miss
   assign midx = laddr_q[INDEX_W-1:0];
   assign hit = state_q == IDLE && cpu_req_i && valid_q[idx] && tag_q[idx] == tag;
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d = tag_q;
      data_d = data_q;
      laddr_d = laddr_q;
      mem_req_o = 1'b0;
      mem_we_o = 1'b0;
      mem_addr_o = '0;
      mem_data_o = '0;
      cpu_stall_o = state_q != IDLE;
      cpu_data_o = hit ? data_q[idx][{w, 5'b0} +: 32] : '0;
      case (state_q)
         IDLE: begin
            if (hit && cpu_we_i) begin
               data_d[idx][{w, 5'b0} +: 32] = cpu_data_i;
               dirty_d[idx] = 1'b1;
            end else if (cpu_req_i && !hit) begin
               cpu_stall_o = 1'b1;
               laddr_d = cpu_addr_i[31:5];
               state_d = valid_q[idx] && dirty_q[idx] ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_req_o = 1'b1;
            mem_we_o = 1'b1;
            mem_addr_o = {tag_q[midx], midx, 5'b0};
            mem_data_o = data_q[midx];
            if (mem_ack_i) begin
               dirty_d[midx] = 1'b0;
               state_d = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_req_o = 1'b1;
            mem_addr_o = {laddr_q, 5'b0};
            if (mem_ack_i) begin
               data_d[midx] = mem_data_i;
               tag_d[midx] = laddr_q[26 -: TAG_W];
               valid_d[midx] = 1'b1;
               dirty_d[midx] = 1'b0;
               state_d = REFILL_DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end
   always_ff @(posedge clk_i) begin
      tag_q <= tag_d;
      data_q <= data_d;
      laddr_q <= laddr_d;
   end
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic replay_q, replay_d;
   // the IDLE cycle right after REFILL_DONE is the replayed miss, not a new hit
   always_comb begin
      replay_d = state_q == REFILL_DONE;
      hit_cnt_d = hit && !replay_q && hit_cnt_q != '1 ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = state_q == IDLE && cpu_req_i && !hit && miss_cnt_q != '1 ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
         replay_q <= 1'b0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         replay_q <= replay_d;
      end
   end
   assign hit_cnt_o = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`else
   assign hit_cnt_o = '0;
   assign miss_cnt_o = '0;
`endif
endmodule
